fht_adc_loader: RTL

FHT_ADC_LOADER -- requirements
Module: fht_adc_loader

---
 rtl/common_types_pkg.sv | 23 ++
 rtl/fht_bitrev_addr.sv | 24 ++
 rtl/fht_adc_loader.sv | 124 ++++++++++++
 3 files changed

// File: rtl/common_types_pkg.sv
// Shared FHT types: loader FSM state encoding and the index bit-reverse helper.
package common_types_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FILL      = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4
  } loader_state_e;

  // Reverses the low 'width' bits of 'value'; bits at and above 'width' come back as zero.
  function automatic logic [31:0] bit_reverse(input logic [31:0] value,
                                              input int unsigned width);
    logic [31:0] rev;
    rev = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < width) rev[i] = value[5'(width - 1 - i)];
    end
    return rev;
  endfunction

endpackage

// File: rtl/fht_bitrev_addr.sv
// Maps a linear sample index to its bit-reversed FHT RAM location:
// the top two reversed bits select the bank, the rest form the in-bank address.
module fht_bitrev_addr
  import common_types_pkg::*;
#(
  parameter int A_BIT = 8
) (
  input  logic [A_BIT+1:0] idx,
  output logic [3:0]       bank_oh,
  output logic [A_BIT-1:0] addr
);

  localparam int unsigned IDX_W = A_BIT + 2;

  logic [IDX_W-1:0] rev;

  // Pure combinational index-to-bank/address translation.
  always_comb begin
    rev     = IDX_W'(bit_reverse(32'(idx), IDX_W));
    addr    = rev[A_BIT-1:0];
    bank_oh = 4'b0001 << rev[A_BIT+1:A_BIT];
  end

endmodule

// File: rtl/fht_adc_loader.sv
// Collects one frame of ADC samples into the four FHT RAM banks in bit-reversed
// order, kicks the transform, and waits for it to finish before loading again.
module fht_adc_loader
  import common_types_pkg::*;
#(
  parameter int D_BIT     = 16,
  parameter int A_BIT     = 8,
  parameter int ADC_WIDTH = 12
) (
  input  logic                 iCLK,
  input  logic                 iRESET,
  input  logic [ADC_WIDTH-1:0] iADC_DATA,
  input  logic                 iADC_VALID,
  input  logic                 iFHT_RDY,
  output logic                 oREADY,
  output logic [3:0]           oWE,
  output logic [A_BIT-1:0]     oADDR_WR,
  output logic [D_BIT-1:0]     oDATA,
  output logic                 oSTART,
  output logic                 oBUSY,
  output logic                 oFRAME_DONE,
  output logic                 oDROP
);

  loader_state_e    state_q, state_d;
  logic [A_BIT+1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic [3:0]       we_q, we_d;
  logic [A_BIT-1:0] addr_q, addr_d;
  logic [D_BIT-1:0] data_q, data_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             drop_q, drop_d;

  logic             accept;
  logic [3:0]       map_bank;
  logic [A_BIT-1:0] map_addr;

  fht_bitrev_addr #(.A_BIT(A_BIT)) u_map (
    .idx     (cnt_q),
    .bank_oh (map_bank),
    .addr    (map_addr)
  );

  // Next-state, counter and registered-output computation.
  always_comb begin
    accept  = iADC_VALID & ready_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    we_d    = '0;
    addr_d  = addr_q;
    data_d  = data_q;
    drop_d  = iADC_VALID & ~ready_q;

    if (accept) begin
      cnt_d  = cnt_q + 1'b1;
      we_d   = map_bank;
      addr_d = map_addr;
      data_d = D_BIT'($signed(iADC_DATA));
    end

    case (state_q)
      ST_IDLE:      if (accept) state_d = ST_FILL;
      ST_FILL:      if (accept && (cnt_q == '1)) state_d = ST_START;
      ST_START: begin
        start_d = 1'b1;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: if (!iFHT_RDY) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (iFHT_RDY) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default:      state_d = ST_IDLE;
    endcase

    // The frame-done cycle is already IDLE but must still refuse samples,
    // so ready is held low for that one cycle.
    ready_d = ((state_d == ST_IDLE) || (state_d == ST_FILL)) && !done_d;
    busy_d  = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      we_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign oREADY      = ready_q;
  assign oWE         = we_q;
  assign oADDR_WR    = addr_q;
  assign oDATA       = data_q;
  assign oSTART      = start_q;
  assign oBUSY       = busy_q;
  assign oFRAME_DONE = done_q;
  assign oDROP       = drop_q;

endmodule
